// File: rtl/bnn_pkg.sv
// Shared BNN parameters and the frame-loader FSM encoding.
package bnn_pkg;
  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
  localparam int PIX_W = 8;
  localparam int NPIX  = IMG_H * IMG_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/bnn_binarize.sv
// Single-pixel binarizer: 1 when the pixel is at or above the threshold.
module bnn_binarize #(
  parameter int PIX_W = bnn_pkg::PIX_W
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] thr,
  output logic             bin
);
  assign bin = (pix >= thr);
endmodule

// File: rtl/bnn_frame_loader.sv
// Streams grayscale pixels row-major into a binary frame buffer and holds the
// completed frame for the BNN stage until it is consumed.
module bnn_frame_loader #(
  parameter int IMG_H = bnn_pkg::IMG_H,
  parameter int IMG_W = bnn_pkg::IMG_W,
  parameter int PIX_W = bnn_pkg::PIX_W
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [PIX_W-1:0]                 thr_i,
  input  logic                             pix_valid_i,
  output logic                             pix_ready_o,
  input  logic [PIX_W-1:0]                 pix_data_i,
  input  logic                             pix_last_i,
  output logic [0:0][IMG_H-1:0][IMG_W-1:0] frame_o,
  output logic                             frame_valid_o,
  input  logic                             frame_ready_i,
  output logic [1:0]                       err_o,
  input  logic                             clear_err_i,
  output logic [15:0]                      frame_cnt_o
);
  import bnn_pkg::*;

  localparam int             NPX    = IMG_H * IMG_W;
  localparam int             CW     = $clog2(NPX);
  localparam logic [CW-1:0]  LAST_K = CW'(NPX - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    pix_cnt_q;
  logic [PIX_W-1:0] thr_q;
  logic [NPX-1:0]   frame_q;
  logic [1:0]       err_q;
  logic [15:0]      frame_cnt_q;

  logic             pix_xfer, first_px, final_px, early_last, pix_bit;
  logic [PIX_W-1:0] thr_use;
  logic [1:0]       err_set;

  assign pix_xfer   = pix_valid_i && (state_q == FILL);
  assign first_px   = (pix_cnt_q == '0);
  assign final_px   = pix_xfer && (pix_cnt_q == LAST_K);
  assign early_last = pix_xfer && pix_last_i && (pix_cnt_q != LAST_K);
  assign err_set    = {final_px && !pix_last_i, early_last};

  // Pixel 0 compares against the live threshold; the rest of the frame uses
  // the copy captured on that same transfer.
  assign thr_use = first_px ? thr_i : thr_q;

  bnn_binarize #(.PIX_W(PIX_W)) u_bin (
    .pix (pix_data_i),
    .thr (thr_use),
    .bin (pix_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (final_px)      state_d = HOLD;
      HOLD:    if (frame_ready_i) state_d = FILL;
      default:                    state_d = FILL;
    endcase
  end

  // Flat frame index k equals row*IMG_W+col, matching the packed frame_o layout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_cnt_q   <= '0;
      thr_q       <= '0;
      frame_q     <= '0;
      err_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (pix_xfer) begin
        frame_q[pix_cnt_q] <= pix_bit;
        if (first_px) thr_q <= thr_i;
        if (final_px || pix_last_i) pix_cnt_q <= '0;
        else                        pix_cnt_q <= pix_cnt_q + 1'b1;
      end
      if (final_px) frame_cnt_q <= frame_cnt_q + 16'd1;
      err_q <= (clear_err_i ? 2'b00 : err_q) | err_set;
    end
  end

  assign pix_ready_o   = (state_q == FILL);
  assign frame_valid_o = (state_q == HOLD);
  assign frame_o       = frame_q;
  assign err_o         = err_q;
  assign frame_cnt_o   = frame_cnt_q;
endmodule
